dm_cache_controller: RTL
========================

Name: dm_cache_controller

Overview:
Write-back, write-allocate controller for the direct-mapped, one-word-per-line cache data array.
- Owns the per-index valid, dirty and tag state internally.
- Drives the data array's write enable, index and write data.
- Sequences line write-back and refill against main memory over a req/ready handshake.
- Sits between the CPU load/store port and the memory bus.

Parameters:
ADDR_W, 32, byte address width
OFFSET_W, 2, byte-offset bits within a word (ignored for lookup)
IDX_W, 5, index bits; IDX_SIZE = 2**IDX_W lines
DATA_W, 32, line/word width
TAG_W (derived), ADDR_W-IDX_W-OFFSET_W, stored tag width

Ports:
iCLK  in  1  clock, all state on rising edge
iRST  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request, sampled in IDLE only
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  access address: tag=[ADDR_W-1:IDX_W+OFFSET_W], idx=[IDX_W+OFFSET_W-1:OFFSET_W]
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  load data, valid when cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
mem_req  out  1  main-memory request
mem_we  out  1  1=write-back, 0=refill read
mem_addr  out  ADDR_W  line address, offset bits zero
mem_wdata  out  DATA_W  write-back data
mem_rdata  in  DATA_W  refill data, valid with mem_ready
mem_ready  in  1  memory completion, one-cycle pulse
data_we  out  1  data array write enable
data_idx  out  IDX_W  data array index
data_block_in  out  DATA_W  data array write data
data_block_out  in  DATA_W  data array combinational read of data_idx
hit_cnt  out  16  saturating hit counter
miss_cnt  out  16  saturating miss counter

Behaviour:
- Reset (iRST=1 at an edge):
  - state to IDLE.
  - All valid and dirty bits cleared; tags don't-care.
  - cpu_ready, mem_req, mem_we, data_we, hit_cnt and miss_cnt to 0.
  - The access register (addr/we/wdata) is cleared.
- Reset mid-operation: the transaction is abandoned and mem_req is 0 in the next cycle. Dirty data in flight is lost by definition.
- The data array write takes effect at the clock edge where data_we=1. Reads are combinational on data_idx.
- data_idx = index of the latched address in every state except IDLE, where it follows cpu_addr.
- IDLE:
  - On cpu_req=1: latch addr/we/wdata and go to COMPARE.
  - cpu_req while not in IDLE is ignored.
- COMPARE:
  - hit = valid[idx] & (tag[idx]==addr tag).
  - Read hit: cpu_rdata=data_block_out, cpu_ready=1, hit_cnt+1, go to IDLE.
  - Write hit: data_we=1, data_block_in=wdata, dirty[idx] set, cpu_ready=1, hit_cnt+1, go to IDLE.
  - Miss: miss_cnt+1. If valid & dirty, go to WRITEBACK; else go to ALLOCATE.
  - A retry COMPARE after a refill does not count again: a "refilled" flag suppresses both counters on the retry.
- WRITEBACK:
  - Drive mem_req=1, mem_we=1, mem_addr={tag[idx], idx, 0}, mem_wdata=data_block_out. All are held stable until mem_ready.
  - On mem_ready: mem_req drops in the next cycle and the state goes to ALLOCATE.
- ALLOCATE:
  - Drive mem_req=1, mem_we=0, mem_addr={addr tag, idx, 0}.
  - On mem_ready: data_we=1, data_block_in=mem_rdata, valid=1, dirty=0, tag updated; go to COMPARE. The retry is a guaranteed hit.
- Latency:
  - Hit: cpu_ready in the cycle after the request is accepted (2 cycles req-to-ready).
  - Clean miss: +1 ALLOCATE cycle + memory latency + 1.
  - Dirty miss: additionally the WRITEBACK phase.
- cpu_ready is high for exactly one cycle. cpu_rdata holds its value until the next completion.
- mem_ready outside WRITEBACK/ALLOCATE is ignored.
- Counters saturate at 0xFFFF and do not wrap.

Test Plan:
1. Reset, then load 0x0000_0040 (idx 16), mem returns 0xDEAD_BEEF after 3 cycles. Required: miss_cnt=1, one mem read at 0x40, cpu_rdata=0xDEAD_BEEF, hit_cnt=0.
2. Repeat the load of 0x40. Required: no mem_req, cpu_ready 2 cycles after req, rdata 0xDEAD_BEEF, hit_cnt=1.
3. Store 0x1234_5678 to 0x40 (hit), then load 0x0000_0840 (same idx, new tag). Required: the store sets no mem_req. The load issues a mem write to 0x40 with 0x1234_5678, then a mem read at 0x840, and returns its data.
4. Load 0x80 (clean miss) then load 0x880 (same idx, clean). Required: no write-back, only a read at 0x880.
5. Assert iRST during ALLOCATE with mem_req high. Required: mem_req=0 next cycle, state IDLE, and a subsequent load of the same address misses (valid cleared).
6. Force hit_cnt to 0xFFFF via 65535 hits, then one more hit. Required: hit_cnt stays 0xFFFF.

Source files
------------

// File: rtl/dm_cache_controller.sv
// Write-back, write-allocate controller for a direct-mapped, one-word-per-line cache.
// Keeps per-line valid/dirty/tag state and sequences write-back and refill on the memory bus.
module dm_cache_controller #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 2,
    parameter int IDX_W    = 5,
    parameter int DATA_W   = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              data_we,
    output logic [IDX_W-1:0]  data_idx,
    output logic [DATA_W-1:0] data_block_in,
    input  logic [DATA_W-1:0] data_block_out,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    localparam int TAG_W    = ADDR_W - IDX_W - OFFSET_W;
    localparam int IDX_SIZE = 2 ** IDX_W;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
    state_t state_reg, state_next;

    logic [TAG_W-1:0]    tag_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                we_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                refilled_reg;
    logic                cpu_ready_reg;
    logic [DATA_W-1:0]   cpu_rdata_reg;
    logic [15:0]         hit_cnt_reg;
    logic [15:0]         miss_cnt_reg;
    logic [IDX_SIZE-1:0] valid_vec;
    logic [IDX_SIZE-1:0] dirty_vec;
    logic [TAG_W-1:0]    tag_mem [IDX_SIZE];

    logic             accept;
    logic             hit_evt;
    logic             miss_evt;
    logic             line_fill;
    logic             set_dirty;
    logic             hit;
    logic             line_dirty;
    logic [TAG_W-1:0] line_tag;
    logic             unused_offset;

    // Byte-offset bits never take part in lookup.
    assign unused_offset = ^cpu_addr[OFFSET_W-1:0];

    assign line_tag   = tag_mem[idx_reg];
    assign hit        = valid_vec[idx_reg] && (line_tag == tag_reg);
    assign line_dirty = valid_vec[idx_reg] && dirty_vec[idx_reg];

    assign cpu_ready = cpu_ready_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign hit_cnt   = hit_cnt_reg;
    assign miss_cnt  = miss_cnt_reg;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        accept        = 1'b0;
        hit_evt       = 1'b0;
        miss_evt      = 1'b0;
        line_fill     = 1'b0;
        set_dirty     = 1'b0;
        data_we       = 1'b0;
        data_idx      = idx_reg;
        data_block_in = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (state_reg)
            IDLE: begin
                data_idx = cpu_addr[IDX_W+OFFSET_W-1:OFFSET_W];
                if (cpu_req) begin
                    accept     = 1'b1;
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    hit_evt    = 1'b1;
                    state_next = IDLE;
                    if (we_reg) begin
                        data_we       = 1'b1;
                        data_block_in = wdata_reg;
                        set_dirty     = 1'b1;
                    end
                end else begin
                    miss_evt   = 1'b1;
                    state_next = line_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {line_tag, idx_reg, {OFFSET_W{1'b0}}};
                mem_wdata = data_block_out;
                if (mem_ready) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = {tag_reg, idx_reg, {OFFSET_W{1'b0}}};
                if (mem_ready) begin
                    data_we       = 1'b1;
                    data_block_in = mem_rdata;
                    line_fill     = 1'b1;
                    state_next    = COMPARE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            tag_reg       <= '0;
            idx_reg       <= '0;
            we_reg        <= 1'b0;
            wdata_reg     <= '0;
            refilled_reg  <= 1'b0;
            cpu_ready_reg <= 1'b0;
            cpu_rdata_reg <= '0;
            hit_cnt_reg   <= '0;
            miss_cnt_reg  <= '0;
        end else begin
            cpu_ready_reg <= hit_evt;
            if (accept) begin
                tag_reg   <= cpu_addr[ADDR_W-1:IDX_W+OFFSET_W];
                idx_reg   <= cpu_addr[IDX_W+OFFSET_W-1:OFFSET_W];
                we_reg    <= cpu_we;
                wdata_reg <= cpu_wdata;
            end
            if (hit_evt && !we_reg) begin
                cpu_rdata_reg <= data_block_out;
            end
            // The retry after a refill is the same access, so it is not counted twice.
            if (line_fill) begin
                refilled_reg <= 1'b1;
            end else if (hit_evt) begin
                refilled_reg <= 1'b0;
            end
            if (hit_evt && !refilled_reg && hit_cnt_reg != 16'hFFFF) begin
                hit_cnt_reg <= hit_cnt_reg + 16'd1;
            end
            if (miss_evt && !refilled_reg && miss_cnt_reg != 16'hFFFF) begin
                miss_cnt_reg <= miss_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (line_fill) begin
            tag_mem[idx_reg] <= tag_reg;
        end
    end

    for (genvar gi = 0; gi < IDX_SIZE; gi++) begin : g_line
        logic valid_reg;
        logic dirty_reg;
        always_ff @(posedge iCLK) begin
            if (iRST) begin
                valid_reg <= 1'b0;
                dirty_reg <= 1'b0;
            end else if (idx_reg == IDX_W'(gi)) begin
                if (line_fill) begin
                    valid_reg <= 1'b1;
                    dirty_reg <= 1'b0;
                end else if (set_dirty) begin
                    dirty_reg <= 1'b1;
                end
            end
        end
        assign valid_vec[gi] = valid_reg;
        assign dirty_vec[gi] = dirty_reg;
    end
endmodule
